regfile_hazard_ctrl: RTL and testbench

//  Scoreboard and issue controller for the 32x32 general register file. Tracks

---
 rtl/regfile_hazard_ctrl.sv | 104 ++++++++++
 tb/tb_regfile_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_hazard_ctrl.sv
// Register-file scoreboard and issue controller: tracks pending writebacks,
// stalls decode on RAW/WAW hazards and registers the regfile read addresses.
module regfile_hazard_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 16,
  localparam int IF_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             RST,
  input  logic             CLK_DC,
  input  logic             ISSUE_VALID,
  output logic             ISSUE_READY,
  input  logic [4:0]       RS1,
  input  logic [4:0]       RS2,
  input  logic             USES_RS1,
  input  logic             USES_RS2,
  input  logic [4:0]       RD,
  input  logic             RD_WE,
  input  logic             WB_VALID,
  input  logic [4:0]       WB_ADDR,
  input  logic             FLUSH,
  output logic [4:0]       A1,
  output logic [4:0]       A2,
  output logic             DC_VALID,
  output logic [31:0]      BUSY,
  output logic [IF_W-1:0]  INFLIGHT,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic             WB_ERR
);

  logic [31:0]      busy_q, busy_d;
  logic [IF_W-1:0]  inflight_q, inflight_d;
  logic [4:0]       a1_q, a1_d, a2_q, a2_d;
  logic             dc_valid_q, dc_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             wb_err_q, wb_err_d;

  logic        clr, set, hazard, counting, full, issue_ready;
  logic [31:0] clr_mask, set_mask, eff_busy;

  always_comb begin
    clr      = WB_VALID && (WB_ADDR != 5'd0) && busy_q[WB_ADDR];
    clr_mask = clr ? (32'd1 << WB_ADDR) : 32'd0;
    // A writeback landing this cycle already resolves the hazard it clears.
    eff_busy = busy_q & ~clr_mask;
    hazard   = (USES_RS1 && (RS1 != 5'd0) && eff_busy[RS1])
            || (USES_RS2 && (RS2 != 5'd0) && eff_busy[RS2])
            || (RD_WE    && (RD  != 5'd0) && eff_busy[RD]);
    counting = RD_WE && (RD != 5'd0);
    full     = (inflight_q - IF_W'(clr)) == IF_W'(MAX_INFLIGHT);
    issue_ready = ISSUE_VALID && !hazard && !(full && counting) && !FLUSH;
    set      = issue_ready && counting;
    set_mask = set ? (32'd1 << RD) : 32'd0;
  end

  // x0 is hardwired zero, so its scoreboard bit never sets.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_d[gi] = !FLUSH && (eff_busy[gi] || set_mask[gi]);
    end
  endgenerate

  always_comb begin
    inflight_d  = FLUSH ? '0 : inflight_q + IF_W'(set) - IF_W'(clr);
    a1_d        = issue_ready ? RS1 : a1_q;
    a2_d        = issue_ready ? RS2 : a2_q;
    dc_valid_d  = issue_ready;
    stall_cnt_d = stall_cnt_q;
    if (ISSUE_VALID && !issue_ready && !FLUSH && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    wb_err_d    = wb_err_q || (WB_VALID && !FLUSH && !clr);
  end

  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      busy_q      <= '0;
      inflight_q  <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      dc_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      dc_valid_q  <= dc_valid_d;
      stall_cnt_q <= stall_cnt_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign ISSUE_READY = issue_ready;
  assign A1          = a1_q;
  assign A2          = a2_q;
  assign DC_VALID    = dc_valid_q;
  assign BUSY        = busy_q;
  assign INFLIGHT    = inflight_q;
  assign STALL_CNT   = stall_cnt_q;
  assign WB_ERR      = wb_err_q;

endmodule

// File: tb/tb_regfile_hazard_ctrl.sv
// Scoreboard bench for regfile_hazard_ctrl: directed hazard scenarios followed
// by randomized traffic checked against a set-of-pending-registers model.
module tb_regfile_hazard_ctrl;
  localparam int MAXI = 4;
  localparam int CW   = 6;
  localparam int IFW  = $clog2(MAXI + 1);
  localparam int SMAX = (1 << CW) - 1;

  logic RST, CLK_DC, ISSUE_VALID, ISSUE_READY, USES_RS1, USES_RS2, RD_WE;
  logic WB_VALID, FLUSH, DC_VALID, WB_ERR;
  logic [4:0] RS1, RS2, RD, WB_ADDR, A1, A2;
  logic [31:0] BUSY;
  logic [IFW-1:0] INFLIGHT;
  logic [CW-1:0] STALL_CNT;

  regfile_hazard_ctrl #(.MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
    .RST(RST), .CLK_DC(CLK_DC), .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY),
    .RS1(RS1), .RS2(RS2), .USES_RS1(USES_RS1), .USES_RS2(USES_RS2),
    .RD(RD), .RD_WE(RD_WE), .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .FLUSH(FLUSH),
    .A1(A1), .A2(A2), .DC_VALID(DC_VALID), .BUSY(BUSY), .INFLIGHT(INFLIGHT),
    .STALL_CNT(STALL_CNT), .WB_ERR(WB_ERR)
  );

  initial CLK_DC = 1'b0;
  always #5 CLK_DC = ~CLK_DC;

  int cyc = 0;
  always @(posedge CLK_DC) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic [4:0] a1;
    logic [4:0] a2;
  } exp_t;
  exp_t q[$];
  exp_t e;

  // Reference model: the set of registers awaiting writeback.
  bit         pend[32];
  int         m_stall;
  bit         m_err;
  logic [4:0] m_a1, m_a2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pend_count();
    int n = 0;
    for (int r = 0; r < 32; r++) if (pend[r]) n++;
    return n;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = pend[r];
    return v;
  endfunction

  function automatic bit still_busy(input logic [4:0] r, input bit clr_ok, input logic [4:0] wba);
    return (r != 5'd0) && pend[r] && !(clr_ok && r == wba);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend[r] = 1'b0;
    m_stall = 0;
    m_err   = 1'b0;
    m_a1    = '0;
    m_a2    = '0;
    q.delete();
  endtask

  task automatic drive_idle();
    ISSUE_VALID = 0; RS1 = 0; RS2 = 0; USES_RS1 = 0; USES_RS2 = 0;
    RD = 0; RD_WE = 0; WB_VALID = 0; WB_ADDR = 0; FLUSH = 0;
  endtask

  task automatic cycle(input bit iv, input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                       input bit we, input bit wbv, input logic [4:0] wba, input bit fl);
    bit clr_ok, haz, counting, room, ready;
    @(posedge CLK_DC);
    #1;
    ISSUE_VALID = iv; RS1 = rs1; USES_RS1 = u1; RS2 = rs2; USES_RS2 = u2;
    RD = rd; RD_WE = we; WB_VALID = wbv; WB_ADDR = wba; FLUSH = fl;
    @(negedge CLK_DC);
    chk("busy", BUSY, pend_vec());
    chk("inflight", 32'(INFLIGHT), pend_count());
    chk("stall_cnt", 32'(STALL_CNT), m_stall);
    chk("wb_err", 32'(WB_ERR), 32'(m_err));
    chk("a1_hold", 32'(A1), 32'(m_a1));
    chk("a2_hold", 32'(A2), 32'(m_a2));
    clr_ok   = wbv && (wba != 5'd0) && pend[wba];
    haz      = (u1 && still_busy(rs1, clr_ok, wba)) || (u2 && still_busy(rs2, clr_ok, wba))
            || (we && still_busy(rd, clr_ok, wba));
    counting = we && (rd != 5'd0);
    room     = (pend_count() - int'(clr_ok)) < MAXI;
    ready    = iv && !haz && (!counting || room) && !fl;
    chk("issue_ready", 32'(ISSUE_READY), 32'(ready));
    if (iv || wbv || fl)
      $display("cyc=%0d iv=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b wb=%0b/%0d fl=%0b -> ready=%0b busy=%08h",
               cyc, iv, rs1, u1, rs2, u2, rd, we, wbv, wba, fl, ready, pend_vec());
    if (fl) begin
      for (int r = 0; r < 32; r++) pend[r] = 1'b0;
    end else begin
      if (clr_ok) pend[wba] = 1'b0;
      if (wbv && !clr_ok) m_err = 1'b1;
      if (ready && counting) pend[rd] = 1'b1;
      if (iv && !ready && m_stall < SMAX) m_stall++;
    end
    if (ready) begin
      m_a1 = rs1;
      m_a2 = rs2;
      q.push_back('{stamp: cyc, a1: rs1, a2: rs2});
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a cycle's negedge: reset drops outputs before the next edge.
  task automatic async_reset();
    #1;
    RST = 1'b0;
    drive_idle();
    #1;
    chk("rst_busy", BUSY, 32'h0);
    chk("rst_inflight", 32'(INFLIGHT), 0);
    chk("rst_stall", 32'(STALL_CNT), 0);
    chk("rst_wb_err", 32'(WB_ERR), 0);
    chk("rst_dc_valid", 32'(DC_VALID), 0);
    chk("rst_a1a2", {22'd0, A1, A2}, 32'h0);
    model_reset();
    @(posedge CLK_DC);
    @(negedge CLK_DC);
    RST = 1'b1;
  endtask

  always @(negedge CLK_DC) begin
    if (RST) begin
      if (DC_VALID) begin
        if (q.size() == 0 || q[0].stamp != cyc - 1) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dc_valid_pulse: got DC_VALID=1 required 0 (cyc %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("a1_issue", 32'(A1), 32'(e.a1));
          chk("a2_issue", 32'(A2), 32'(e.a2));
        end
      end else if (q.size() > 0 && q[0].stamp == cyc - 1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dc_valid_pulse: got DC_VALID=0 required 1 (cyc %0d)", cyc);
        void'(q.pop_front());
      end
    end
  end

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int pl[$];
    logic [4:0] wba;
    bit wbv;
    RST = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) @(negedge CLK_DC);
    chk("reset_busy", BUSY, 32'h0);
    chk("reset_stall", 32'(STALL_CNT), 0);
    chk("reset_dc_valid", 32'(DC_VALID), 0);
    RST = 1'b1;

    // RAW stall on x5, saturating stall counter, same-cycle writeback bypass
    cycle(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    repeat (70) cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_saturated", 32'(STALL_CNT), SMAX);
    cycle(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    idle();
    chk("x5_cleared", BUSY, 32'h0);

    // RD=0 with write enable neither sets a bit nor counts
    cycle(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    idle();
    chk("rd0_busy", BUSY, 32'h0);
    chk("rd0_a1", 32'(A1), 0);

    // fill to MAX_INFLIGHT, stall, then accept alongside a writeback
    for (int r = 1; r <= 4; r++) cycle(1, 0, 0, 0, 0, 5'(r), 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 6, 1, 1, 2, 0);
    idle();
    chk("full_busy", BUSY, 32'h5A);
    chk("full_inflight", 32'(INFLIGHT), 4);

    // writeback and re-issue of the same destination in one cycle
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    idle();
    chk("waw_busy7", 32'(BUSY[7]), 1);
    chk("waw_inflight", 32'(INFLIGHT), 4);

    // writeback to an idle register is a sticky error
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    idle();
    chk("wb_err_set", 32'(WB_ERR), 1);
    chk("wb_err_busy", BUSY, 32'h0000_00D8);

    // flush with traffic: scoreboard cleared, no issue
    cycle(1, 1, 1, 0, 0, 10, 1, 1, 3, 1);
    idle();
    chk("flush_busy", BUSY, 32'h0);
    chk("flush_inflight", 32'(INFLIGHT), 0);

    // asynchronous reset in the middle of a stall
    cycle(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    async_reset();

    for (int i = 0; i < 1500; i++) begin
      pl.delete();
      for (int r = 1; r < 32; r++) if (pend[r]) pl.push_back(r);
      wbv = ($urandom_range(0, 9) < 4);
      if (pl.size() > 0 && $urandom_range(0, 3) != 0) wba = 5'(pl[$urandom_range(0, pl.size() - 1)]);
      else wba = rreg();
      cycle($urandom_range(0, 9) < 8, rreg(), 1'($urandom_range(0, 1)), rreg(),
            1'($urandom_range(0, 1)), rreg(), $urandom_range(0, 9) < 7, wbv, wba,
            $urandom_range(0, 99) < 3);
      if (i % 400 == 399) async_reset();
    end

    idle();
    idle();
    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
